input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//  Upstream conditioning stage for the edge detector. Brings WIDTH asynchronous raw inputs into clk domain via
//  2-flop synchronizer, then debounces each bit independently: a bit's output changes only after the synchronized
//  input has differed from it for STABLE_CYCLES consecutive clocks. signal_out drives the edge detector's signal.
// PARAMETERS
//  WIDTH          1  number of independent input bits
//  STABLE_CYCLES  4  consecutive mismatching cycles required to accept a new level (>=1)
// PORTS
//  clk         input   1      system clock, all logic on rising edge
//  n_rst       input   1      reset, synchronous, active-low
//  raw_in      input   WIDTH  asynchronous raw inputs (buttons, pins)
//  signal_out  output  WIDTH  debounced, synchronized level; feeds edge detector signal
//  settled     output  1      high when every synchronized bit equals its debounced bit
// BEHAVIOUR
//  Reset (n_rst==0 at rising edge): sync1, sync2, deb, all counters <= 0. signal_out=0, settled=1.
//   Reset has priority over all other updates; raw_in ignored while in reset.
//  Synchronizer: sync1 <= raw_in; sync2 <= sync1. No logic between flops.
//  Per bit i, counter cnt[i], width CNT_W = max(1, $clog2(STABLE_CYCLES)):
//   - sync2[i]==deb[i]                   : cnt[i] <= 0 (any glitch shorter than threshold discarded)
//   - sync2[i]!=deb[i], cnt[i]==STABLE_CYCLES-1 : deb[i] <= sync2[i]; cnt[i] <= 0
//   - sync2[i]!=deb[i], otherwise        : cnt[i] <= cnt[i]+1
//  Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.
//  signal_out = deb (registered, glitch-free). settled = (sync2 == deb), combinational from flops.
//  Latency: raw bit changes and stays stable; first sampling edge = edge 1 -> signal_out changes at edge
//   STABLE_CYCLES+2 (edge 6 for default). Bits are fully independent; simultaneous changes on several bits
//   each resolve on their own schedule.
//  STABLE_CYCLES==1: deb follows sync2 one cycle later (latency 3 edges); counter unused, stays 0.
//  Reset mid-count: counters and outputs cleared; next transition needs full latency again.
//  Input reverting to the old level before threshold: counter cleared that cycle; output never toggles.
// TESTING
//  1 Reset: raw_in=all ones, n_rst low 2 edges -> signal_out=0, settled=1; after release, signal_out=all ones
//    at edge 6.
//  2 Clean rise, WIDTH=4, STABLE_CYCLES=4: raw_in 0000->0001 held -> signal_out[0] low through edge 5,
//    high at edge 6; settled low after edges 2..5, high from edge 6.
//  3 Glitch: raw_in[0] high for 3 cycles then low -> signal_out stays 0, cnt returns to 0, settled back to 1.
//  4 Independent bits: bit0 rises at edge 1, bit1 at edge 3 -> signal_out[0] at edge 6, [1] at edge 8;
//    falling back via same rule.
//  5 Reset mid-count: bit0 rising, n_rst low at edge 4 for 1 edge, then released with raw still high ->
//    signal_out=0 during reset, rises 6 edges after release.
//  6 STABLE_CYCLES=1: raw_in 0->1 -> signal_out high at edge 3; 1-cycle pulse still passes (documented limit).

Source files
------------

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchronizer plus per-bit debounce.
// Each bit accepts a new level after STABLE_CYCLES mismatching clocks.
module input_debouncer #(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] signal_out,
  output logic             settled
);

  localparam int CNT_W =
    (STABLE_CYCLES <= 2) ? 1 : $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Any mismatch shorter than the threshold clears the count.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign signal_out = deb;
  assign settled    = (sync2 == deb);

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of sync latency,
// glitch rejection, bit independence and reset.
module tb_input_debouncer;

  logic       clk;
  logic       n_rst;
  logic [3:0] raw4;
  logic [3:0] out4;
  logic       settled4;
  logic [0:0] raw1;
  logic [0:0] out1;
  logic       settled1;

  int checks;
  int errors;

  input_debouncer #(
    .WIDTH(4),
    .STABLE_CYCLES(4)
  ) dut4 (
    .clk(clk),
    .n_rst(n_rst),
    .raw_in(raw4),
    .signal_out(out4),
    .settled(settled4)
  );

  input_debouncer #(
    .WIDTH(1),
    .STABLE_CYCLES(1)
  ) dut1 (
    .clk(clk),
    .n_rst(n_rst),
    .raw_in(raw1),
    .signal_out(out1),
    .settled(settled1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    raw4  = '0;
    raw1  = '0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    n_rst = 1'b0;
    raw4  = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (out4 !== 4'b0000 || settled4 !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: out=%b settled=%b want 0000/1",
                 out4, settled4);
      end
    end
    n_rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = (e >= 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (out4 !== exp) begin
        errors++;
        $display("FAIL reset_release e%0d: out=%b want %b",
                 e, out4, exp);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [3:0] exp;
    logic       exp_s;
    apply_reset();
    raw4 = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp   = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_s = !(e >= 2 && e <= 5);
      checks++;
      if (out4 !== exp || settled4 !== exp_s) begin
        errors++;
        $display("FAIL clean_rise e%0d: out=%b s=%b want %b/%b",
                 e, out4, settled4, exp, exp_s);
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_s;
    apply_reset();
    raw4 = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      if (e == 4) raw4 = 4'b0000;
      tick();
      exp_s = !(e >= 2 && e <= 4);
      checks++;
      if (out4 !== 4'b0000 || settled4 !== exp_s) begin
        errors++;
        $display("FAIL glitch e%0d: out=%b s=%b want 0000/%b",
                 e, out4, settled4, exp_s);
      end
    end
    // a fresh rise must need the full latency again
    raw4 = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (out4[0] !== (e >= 6)) begin
        errors++;
        $display("FAIL glitch_rerise e%0d: out0=%b want %b",
                 e, out4[0], (e >= 6));
      end
    end
  endtask

  task automatic test_independent();
    logic [3:0] exp;
    apply_reset();
    raw4 = 4'b0001;
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) raw4 = 4'b0011;
      tick();
      exp = {2'b00, (e >= 8), (e >= 6)};
      checks++;
      if (out4 !== exp) begin
        errors++;
        $display("FAIL indep_rise e%0d: out=%b want %b",
                 e, out4, exp);
      end
    end
    raw4 = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e >= 6) ? 4'b0000 : 4'b0011;
      checks++;
      if (out4 !== exp) begin
        errors++;
        $display("FAIL indep_fall e%0d: out=%b want %b",
                 e, out4, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    raw4 = 4'b0001;
    tick();
    tick();
    tick();
    n_rst = 1'b0;
    tick();
    checks++;
    if (out4 !== 4'b0000 || settled4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold: out=%b s=%b want 0000/1",
               out4, settled4);
    end
    n_rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (out4[0] !== (e >= 6)) begin
        errors++;
        $display("FAIL reset_mid e%0d: out0=%b want %b",
                 e, out4[0], (e >= 6));
      end
    end
  endtask

  task automatic test_single_cycle();
    logic exp;
    apply_reset();
    raw1 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp = (e >= 3);
      checks++;
      if (out1 !== exp) begin
        errors++;
        $display("FAIL sc1_rise e%0d: out=%b want %b",
                 e, out1, exp);
      end
    end
    raw1 = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    checks++;
    if (out1 !== 1'b0 || settled1 !== 1'b1) begin
      errors++;
      $display("FAIL sc1_fall: out=%b s=%b want 0/1",
               out1, settled1);
    end
    // one-cycle pulse passes straight through
    raw1 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      raw1 = 1'b0;
      exp  = (e == 3);
      checks++;
      if (out1 !== exp) begin
        errors++;
        $display("FAIL sc1_pulse e%0d: out=%b want %b",
                 e, out1, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst  = 1'b0;
    raw4   = '0;
    raw1   = '0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_independent();
    test_reset_mid();
    test_single_cycle();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
